rr_resource_scheduler: RTL and testbench

- Round-robin scheduler that shares one fixed-latency resource between N pipelines.
- Issues a one-hot grant per cycle and supports bounded burst locking.
- Tracks each grant through a LATENCY-deep tag pipe, so each requester gets its own qualified return-valid and the wrapper gets the select for the return mux.
- A per-requester flush cancels that requester's pending request and all of its in-flight returns.

---
 rtl/rr_resource_scheduler.sv | 150 +++++++++++++++
 tb/tb_rr_resource_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_resource_scheduler.sv
// Round-robin scheduler sharing one fixed-latency resource between N requesters, with
// bounded burst locking and per-requester flush. Optional starvation monitor: RR_SCHED_STARVE_MON_EN.
module rr_resource_scheduler #(
   parameter int unsigned N         = 2,
   parameter int unsigned LATENCY   = 1,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         req,
   input  logic [N-1:0]         lock,
   input  logic [N-1:0]         flush,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_idx,
   output logic [N-1:0]         rsp_valid,
   output logic [$clog2(N)-1:0] rsp_sel,
`ifdef RR_SCHED_STARVE_MON_EN
   output logic [N-1:0]         starve_err,
`endif
   output logic                 busy
);

   localparam int unsigned IW       = $clog2(N);
   localparam int unsigned LAST     = LATENCY - 1;
   localparam logic [3:0]  MaxBurst = 4'(MAX_BURST);

   logic [N-1:0]       elig;
   logic [IW-1:0]      ptr_q;
   logic [IW-1:0]      owner_q;
   logic               owner_vld_q;
   logic [3:0]         burst_q;
   logic               lock_hit;
   logic               rr_found;
   logic [IW-1:0]      rr_idx;
   logic               any_grant;
   int unsigned        scan_j;

   logic [LATENCY-1:0] tag_vld_q;
   logic [LATENCY-1:0] tag_vld_d;
   logic [IW-1:0]      tag_idx_q [LATENCY];
   logic [IW-1:0]      tag_idx_d [LATENCY];
   logic               busy_q;
   logic               busy_d;

   // Arbitration: a locked owner under its burst bound wins, otherwise first eligible from ptr.
   always_comb begin
      elig     = reset ? '0 : (req & ~flush);
      lock_hit = owner_vld_q && elig[owner_q] && lock[owner_q] && (burst_q < MaxBurst);
      rr_found = 1'b0;
      rr_idx   = '0;
      scan_j   = 0;
      for (int unsigned k = 0; k < N; k++) begin
         scan_j = (32'(ptr_q) + k) % N;
         if (!rr_found && elig[scan_j[IW-1:0]]) begin
            rr_found = 1'b1;
            rr_idx   = scan_j[IW-1:0];
         end
      end
      any_grant = lock_hit | rr_found;
      grant_idx = lock_hit ? owner_q : rr_idx;
      grant     = '0;
      if (any_grant) begin
         grant[grant_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q       <= '0;
         owner_q     <= '0;
         owner_vld_q <= 1'b0;
         burst_q     <= '0;
      end else if (any_grant) begin
         ptr_q       <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
         owner_q     <= grant_idx;
         owner_vld_q <= 1'b1;
         if (owner_vld_q && (owner_q == grant_idx)) begin
            burst_q <= (burst_q >= MaxBurst) ? burst_q : burst_q + 4'd1;
         end else begin
            burst_q <= '0;
         end
      end else begin
         owner_vld_q <= 1'b0;
         burst_q     <= '0;
      end
   end

   // Tag pipe: a flush kills every in-flight tag belonging to that requester.
   always_comb begin
      tag_vld_d    = '0;
      tag_idx_d    = '{default: '0};
      tag_vld_d[0] = any_grant;
      tag_idx_d[0] = grant_idx;
      for (int unsigned k = 1; k < LATENCY; k++) begin
         tag_vld_d[k] = tag_vld_q[k-1] & ~flush[tag_idx_q[k-1]];
         tag_idx_d[k] = tag_idx_q[k-1];
      end
      busy_d = |tag_vld_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_vld_q <= '0;
         tag_idx_q <= '{default: '0};
         busy_q    <= 1'b0;
      end else begin
         tag_vld_q <= tag_vld_d;
         tag_idx_q <= tag_idx_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      rsp_valid = '0;
      rsp_sel   = '0;
      if (tag_vld_q[LAST] && !flush[tag_idx_q[LAST]]) begin
         rsp_valid[tag_idx_q[LAST]] = 1'b1;
         rsp_sel                    = tag_idx_q[LAST];
      end
   end

   assign busy = busy_q;

`ifdef RR_SCHED_STARVE_MON_EN
   logic [7:0]   wait_q [N];
   logic [N-1:0] starve_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_q   <= '{default: '0};
         starve_q <= '0;
      end else begin
         for (int unsigned i = 0; i < N; i++) begin
            if (grant[i] || flush[i]) begin
               wait_q[i]   <= '0;
               starve_q[i] <= 1'b0;
            end else begin
               if (elig[i] && (wait_q[i] != 8'hff)) begin
                  wait_q[i] <= wait_q[i] + 8'd1;
               end
               starve_q[i] <= elig[i] && (wait_q[i] == 8'd15);
            end
         end
      end
   end

   assign starve_err = starve_q;
`endif

endmodule

// File: tb/tb_rr_resource_scheduler.sv
// Randomized scoreboard bench for rr_resource_scheduler against a queue-based reference model.
module tb_rr_resource_scheduler;

   localparam int unsigned N         = 3;
   localparam int unsigned LATENCY   = 3;
   localparam int unsigned MAX_BURST = 4;
   localparam int unsigned IW        = $clog2(N);

   logic          clk   = 1'b0;
   logic          reset = 1'b0;
   logic [N-1:0]  req   = '0;
   logic [N-1:0]  lock  = '0;
   logic [N-1:0]  flush = '0;
   logic [N-1:0]  grant;
   logic [IW-1:0] grant_idx;
   logic [N-1:0]  rsp_valid;
   logic [IW-1:0] rsp_sel;
   logic          busy;
`ifdef RR_SCHED_STARVE_MON_EN
   logic [N-1:0]  starve_err;
`endif

   rr_resource_scheduler #(
      .N         (N),
      .LATENCY   (LATENCY),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .lock      (lock),
      .flush     (flush),
      .grant     (grant),
      .grant_idx (grant_idx),
      .rsp_valid (rsp_valid),
      .rsp_sel   (rsp_sel),
`ifdef RR_SCHED_STARVE_MON_EN
      .starve_err(starve_err),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int idx;
      int due;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   m_ptr    = 0;
   int   m_last   = -1;
   int   m_run    = 0;
`ifdef RR_SCHED_STARVE_MON_EN
   int           m_wait [N];
   logic [N-1:0] m_starve;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_ptr  = 0;
      m_last = -1;
      m_run  = 0;
`ifdef RR_SCHED_STARVE_MON_EN
      for (int i = 0; i < N; i++) m_wait[i] = 0;
      m_starve = '0;
`endif
   endtask

   // One clock cycle: drive inputs, predict grant from the arbitration rules, log the return.
   task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N-1:0] f);
      int           g;
      logic [N-1:0] elig;
      logic [N-1:0] oh;
      exp_t         nq[$];
      @(posedge clk);
      cyc++;
      #1;
      req   = r;
      lock  = l;
      flush = f;
      #1;
      check("busy", 32'(busy), 32'(exp_q.size() != 0));
      elig = r & ~f;
      g    = -1;
      if (m_last >= 0 && elig[m_last] && l[m_last] && m_run < int'(MAX_BURST)) begin
         g = m_last;
      end else begin
         for (int k = 0; k < int'(N); k++) begin
            int j;
            j = (m_ptr + k) % int'(N);
            if (g < 0 && elig[j]) g = j;
         end
      end
      oh = '0;
      if (g >= 0) oh[g] = 1'b1;
      check("grant", 32'(grant), 32'(oh));
      check("grant_idx", 32'(grant_idx), (g < 0) ? 32'd0 : 32'(g));
`ifdef RR_SCHED_STARVE_MON_EN
      check("starve_err", 32'(starve_err), 32'(m_starve));
      for (int i = 0; i < int'(N); i++) begin
         if (oh[i] || f[i]) begin
            m_starve[i] = 1'b0;
            m_wait[i]   = 0;
         end else begin
            m_starve[i] = elig[i] && (m_wait[i] == 15);
            if (elig[i] && m_wait[i] < 255) m_wait[i]++;
         end
      end
`endif
      foreach (exp_q[i]) begin
         if (!f[exp_q[i].idx]) nq.push_back(exp_q[i]);
      end
      exp_q = nq;
      if (g >= 0) begin
         exp_q.push_back('{idx: g, due: cyc + int'(LATENCY)});
         if (g == m_last) m_run = (m_run < int'(MAX_BURST)) ? m_run + 1 : m_run;
         else m_run = 0;
         m_last = g;
         m_ptr  = (g + 1) % int'(N);
      end else begin
         m_last = -1;
         m_run  = 0;
      end
   endtask

   task automatic apply_reset();
      #1;
      reset = 1'b1;
      #1;
      check("reset_grant", 32'(grant), 32'd0);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      req   = '0;
      lock  = '0;
      flush = '0;
      reset = 1'b0;
   endtask

   // Response monitor: pops the scoreboard whenever a return is presented or is due.
   initial begin
      exp_t         e;
      logic [N-1:0] moh;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (rsp_valid != '0) begin
               if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
                  check("rsp_unexpected", 32'(rsp_valid), 32'd0);
               end else begin
                  e      = exp_q.pop_front();
                  moh    = '0;
                  moh[e.idx] = 1'b1;
                  check("rsp_valid", 32'(rsp_valid), 32'(moh));
                  check("rsp_sel", 32'(rsp_sel), 32'(e.idx));
               end
            end else if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
               e      = exp_q.pop_front();
               moh    = '0;
               moh[e.idx] = 1'b1;
               check("rsp_missing", 32'(rsp_valid), 32'(moh));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      logic [N-1:0] r;
      logic [N-1:0] l;
      logic [N-1:0] f;
      #1;
      reset = 1'b1;
      #1;
      check("init_grant", 32'(grant), 32'd0);
      check("init_rsp_valid", 32'(rsp_valid), 32'd0);
      check("init_busy", 32'(busy), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;

      repeat (6) step(3'b111, 3'b000, 3'b000);
      repeat (4) step(3'b000, 3'b000, 3'b000);
      repeat (9) step(3'b011, 3'b001, 3'b000);
      repeat (4) step(3'b000, 3'b000, 3'b000);
      // Flush requester 1 while its tag is in flight; requester 0's tag must survive.
      step(3'b010, 3'b000, 3'b000);
      step(3'b001, 3'b000, 3'b000);
      step(3'b000, 3'b000, 3'b010);
      repeat (5) step(3'b000, 3'b000, 3'b000);
      step(3'b010, 3'b000, 3'b010);
      step(3'b010, 3'b000, 3'b000);
      repeat (4) step(3'b000, 3'b000, 3'b000);
      repeat (3) step(3'b011, 3'b001, 3'b000);
      apply_reset();
      step(3'b011, 3'b000, 3'b000);
      repeat (4) step(3'b000, 3'b000, 3'b000);

      repeat (600) begin
         r = N'($urandom);
         l = N'($urandom & $urandom);
         f = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
         step(r, l, f);
      end
      repeat (LATENCY + 2) step(3'b000, 3'b000, 3'b000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
